// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response port shared by fetch, data and the downstream memory side.
// Masters drive the request fields; slaves return addr_ok, data_ok and rdata.
interface mem_req_arbiter_if;
  logic        req;
  logic        wr;
  logic        cache;
  logic [2:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, cache, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, cache, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Fetch/data arbiter onto one SRAM-like port: zero-cycle request path, grant held until addr_ok.
// An in-order owner FIFO steers each data_ok back; requests are blocked while DEPTH are outstanding.
module mem_req_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  mem_req_arbiter_if.slave       i,
  mem_req_arbiter_if.slave       d,
  mem_req_arbiter_if.master      m,
  output logic                   err
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {ID_INST = 1'b0, ID_DATA = 1'b1} owner_e;

  logic             lock;
  owner_e           lock_id;
  logic [DEPTH-1:0] owner_q;
  logic [PW-1:0]    rptr, wptr;
  logic [PW:0]      cnt;
  logic [SW-1:0]    streak;

  owner_e gnt;
  logic   sel_d, full, starved, push, pop, head;

  assign starved = (streak == STREAK_MAX);
  assign full    = (cnt == FULL_CNT);

  // With nobody requesting the grant defaults to data, so idle fields follow the data master.
  always_comb begin
    gnt = ID_DATA;
    if (lock)
      gnt = lock_id;
    else if (i.req && (!d.req || starved))
      gnt = ID_INST;
  end

  assign sel_d   = (gnt == ID_DATA);
  assign m.req   = (sel_d ? d.req : i.req) && !full;
  assign m.wr    = sel_d ? d.wr    : i.wr;
  assign m.cache = sel_d ? d.cache : i.cache;
  assign m.size  = sel_d ? d.size  : i.size;
  assign m.wstrb = sel_d ? d.wstrb : i.wstrb;
  assign m.addr  = sel_d ? d.addr  : i.addr;
  assign m.wdata = sel_d ? d.wdata : i.wdata;

  assign push      = m.req && m.addr_ok;
  assign i.addr_ok = push && !sel_d;
  assign d.addr_ok = push && sel_d;

  assign pop       = m.data_ok && (cnt != '0);
  assign head      = owner_q[rptr];
  assign i.data_ok = pop && !head;
  assign d.data_ok = pop && head;
  assign i.rdata   = m.rdata;
  assign d.rdata   = m.rdata;

  always_ff @(posedge clk) begin
    if (push)
      owner_q[wptr] <= sel_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock    <= 1'b0;
      lock_id <= ID_INST;
      rptr    <= '0;
      wptr    <= '0;
      cnt     <= '0;
      streak  <= '0;
      err     <= 1'b0;
    end else begin
      if (push) begin
        lock <= 1'b0;
      end else if (m.req) begin
        lock    <= 1'b1;
        lock_id <= gnt;
      end

      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

      if (m.data_ok && (cnt == '0))
        err <= 1'b1;

      // Counts data wins against a waiting fetch; any fetch win or idle fetch resets it.
      if (!i.req || (push && !sel_d))
        streak <= '0;
      else if (push && sel_d && !starved)
        streak <= streak + 1'b1;
    end
  end
endmodule
